// File: rtl/busca_pkg.sv
// Shared definitions for the instruction fetch unit: FSM encoding and reset constants.
// BUSCA_TIMEOUT_EN adds the ERRO state and the fetch-timeout limit.
package busca_pkg;

`ifdef BUSCA_TIMEOUT_EN
    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        BUSCA   = 2'd1,
        ENTREGA = 2'd2,
        ERRO    = 2'd3
    } estado_t;
`else
    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        BUSCA   = 2'd1,
        ENTREGA = 2'd2
    } estado_t;
`endif

    localparam logic [7:0] PC_RESET    = 8'h00;
    localparam logic [7:0] INSTR_NOP   = 8'h00;
    localparam logic [3:0] TIMEOUT_MAX = 4'd15;

endpackage

// File: rtl/contador_pc.sv
// Program counter register with increment / taken-branch select.
module contador_pc
    import busca_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       carrega,
    input  logic       desvia,
    input  logic [7:0] alvo,
    output logic [7:0] pc
);

    logic [7:0] pc_q, pc_d;

    always_comb begin
        pc_d = pc_q;
        if (carrega) begin
            // 8-bit add wraps 0xFF to 0x00
            pc_d = desvia ? alvo : pc_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q <= PC_RESET;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/unidade_busca.sv
// Instruction fetch unit: single outstanding fetch, hands one instruction at a time to controleUnit.
// Define BUSCA_TIMEOUT_EN to enable the fetch-timeout counter and the sticky ERRO state.
module unidade_busca
    import busca_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    output logic [7:0] mem_addr,
    output logic       mem_req,
    input  logic       mem_ack,
    input  logic [7:0] mem_data,
    output logic [7:0] instru,
    output logic       instru_valida,
    input  logic       escritaPC,
    input  logic       pula,
    input  logic       comparador,
    input  logic [7:0] alvo,
    output logic [7:0] pc,
    output logic       erro_busca
);

    estado_t    estado_q, estado_d;
    logic [7:0] instru_q;
    logic       carrega;

    assign carrega = (estado_q == ENTREGA) && escritaPC;

    contador_pc u_contador_pc (
        .clk     (clk),
        .reset   (reset),
        .carrega (carrega),
        .desvia  (pula & comparador),
        .alvo    (alvo),
        .pc      (pc)
    );

`ifdef BUSCA_TIMEOUT_EN
    logic [3:0] espera_q, espera_d;

    // Counts consecutive BUSCA cycles without an ack; cleared whenever BUSCA is left or acked.
    assign espera_d = ((estado_q == BUSCA) && !mem_ack) ? espera_q + 4'd1 : 4'd0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            espera_q <= 4'd0;
        end else begin
            espera_q <= espera_d;
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado_q <= OCIOSO;
            instru_q <= INSTR_NOP;
        end else begin
            estado_q <= estado_d;
            if ((estado_q == BUSCA) && mem_ack) begin
                instru_q <= mem_data;
            end
        end
    end

    always_comb begin
        estado_d = estado_q;
        unique case (estado_q)
            OCIOSO:  estado_d = BUSCA;
            BUSCA: begin
                if (mem_ack) begin
                    estado_d = ENTREGA;
                end
`ifdef BUSCA_TIMEOUT_EN
                // The 15th unanswered cycle gives up
                else if (espera_q == TIMEOUT_MAX - 4'd1) begin
                    estado_d = ERRO;
                end
`endif
            end
            ENTREGA: begin
                if (escritaPC) begin
                    estado_d = BUSCA;
                end
            end
            default: estado_d = estado_q;
        endcase
    end

    always_comb begin
        mem_req       = (estado_q == BUSCA);
        mem_addr      = pc;
        instru_valida = (estado_q == ENTREGA);
        instru        = instru_q;
`ifdef BUSCA_TIMEOUT_EN
        erro_busca    = (estado_q == ERRO);
        if (estado_q == ERRO) begin
            instru = INSTR_NOP;
        end
`else
        erro_busca    = 1'b0;
`endif
    end

endmodule

// File: tb/tb_unidade_busca.sv
// Self-checking bench for unidade_busca: directed scenarios plus a randomized run against a model.
module tb_unidade_busca;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] mem_addr;
    logic       mem_req;
    logic       mem_ack;
    logic [7:0] mem_data;
    logic [7:0] instru;
    logic       instru_valida;
    logic       escritaPC;
    logic       pula;
    logic       comparador;
    logic [7:0] alvo;
    logic [7:0] pc;
    logic       erro_busca;

    int errors = 0;
    int checks = 0;

    unidade_busca dut (
        .clk           (clk),
        .reset         (reset),
        .mem_addr      (mem_addr),
        .mem_req       (mem_req),
        .mem_ack       (mem_ack),
        .mem_data      (mem_data),
        .instru        (instru),
        .instru_valida (instru_valida),
        .escritaPC     (escritaPC),
        .pula          (pula),
        .comparador    (comparador),
        .alvo          (alvo),
        .pc            (pc),
        .erro_busca    (erro_busca)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [7:0] data);
        mem_ack  = 1'b1;
        mem_data = data;
        tick();
        mem_ack  = 1'b0;
    endtask

    task automatic retire(input logic p, input logic c, input logic [7:0] a);
        escritaPC  = 1'b1;
        pula       = p;
        comparador = c;
        alvo       = a;
        tick();
        escritaPC  = 1'b0;
        pula       = 1'b0;
        comparador = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1;
        checks++;
        if ({mem_req, mem_addr, instru, instru_valida, pc, erro_busca} !== 27'd0) begin
            errors++;
            $display("FAIL reset_state: got req=%b addr=%h instru=%h valida=%b pc=%h erro=%b, want all zero",
                     mem_req, mem_addr, instru, instru_valida, pc, erro_busca);
        end
        tick();
        tick();
        reset = 1'b0;
        tick();
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 8'h00) begin
            errors++;
            $display("FAIL first_req: got req=%b addr=%h, want req=1 addr=00", mem_req, mem_addr);
        end
    endtask

    task automatic test_first_fetch();
        tick();
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 8'h00 || instru_valida !== 1'b0) begin
            errors++;
            $display("FAIL hold_req: got req=%b addr=%h valida=%b, want 1 00 0",
                     mem_req, mem_addr, instru_valida);
        end
        fetch(8'h3A);
        checks++;
        if (instru !== 8'h3A || instru_valida !== 1'b1 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL first_fetch: got instru=%h valida=%b req=%b, want 3a 1 0",
                     instru, instru_valida, mem_req);
        end
        // A stray ack while delivering must not disturb the held instruction
        fetch(8'hC4);
        tick();
        checks++;
        if (instru !== 8'h3A || instru_valida !== 1'b1 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL ack_ignored: got instru=%h valida=%b req=%b, want 3a 1 0",
                     instru, instru_valida, mem_req);
        end
    endtask

    task automatic test_increment();
        retire(1'b1, 1'b1, 8'h05);
        fetch(8'h11);
        retire(1'b0, 1'b1, 8'h99);
        checks++;
        if (pc !== 8'h06 || instru_valida !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 8'h06) begin
            errors++;
            $display("FAIL increment: got pc=%h valida=%b req=%b addr=%h, want 06 0 1 06",
                     pc, instru_valida, mem_req, mem_addr);
        end
    endtask

    task automatic test_branch();
        fetch(8'h22);
        retire(1'b1, 1'b1, 8'h80);
        checks++;
        if (pc !== 8'h80 || mem_addr !== 8'h80) begin
            errors++;
            $display("FAIL branch_taken: got pc=%h addr=%h, want 80 80", pc, mem_addr);
        end
        fetch(8'h33);
        retire(1'b1, 1'b0, 8'h33);
        checks++;
        if (pc !== 8'h81) begin
            errors++;
            $display("FAIL branch_not_taken: got pc=%h, want 81", pc);
        end
        // Branch inputs outside ENTREGA must be ignored
        escritaPC = 1'b1; pula = 1'b1; comparador = 1'b1; alvo = 8'h44;
        tick();
        escritaPC = 1'b0; pula = 1'b0; comparador = 1'b0;
        checks++;
        if (pc !== 8'h81 || mem_req !== 1'b1) begin
            errors++;
            $display("FAIL retire_outside_entrega: got pc=%h req=%b, want 81 1", pc, mem_req);
        end
    endtask

    task automatic test_wrap();
        fetch(8'h44);
        retire(1'b1, 1'b1, 8'hFF);
        fetch(8'h55);
        retire(1'b0, 1'b0, 8'h00);
        checks++;
        if (pc !== 8'h00 || mem_req !== 1'b1 || mem_addr !== 8'h00) begin
            errors++;
            $display("FAIL wrap: got pc=%h req=%b addr=%h, want 00 1 00", pc, mem_req, mem_addr);
        end
    endtask

    task automatic test_reset_mid_fetch();
        fetch(8'h66);
        retire(1'b1, 1'b1, 8'h10);
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 8'h10) begin
            errors++;
            $display("FAIL pre_reset_req: got req=%b addr=%h, want 1 10", mem_req, mem_addr);
        end
        reset    = 1'b1;
        mem_ack  = 1'b1;
        mem_data = 8'h77;
        #1;
        checks++;
        if (mem_req !== 1'b0 || pc !== 8'h00 || instru_valida !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got req=%b pc=%h valida=%b, want 0 00 0",
                     mem_req, pc, instru_valida);
        end
        tick();
        reset = 1'b0;
        tick();
        mem_ack = 1'b0;
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 8'h00 || instru_valida !== 1'b0 || instru !== 8'h00) begin
            errors++;
            $display("FAIL post_reset_fetch: got req=%b addr=%h valida=%b instru=%h, want 1 00 0 00",
                     mem_req, mem_addr, instru_valida, instru);
        end
        tick();
        checks++;
        if (instru_valida !== 1'b0) begin
            errors++;
            $display("FAIL no_ack_no_valid: got valida=%b, want 0", instru_valida);
        end
    endtask

    // Enters with a fresh fetch that has already waited one unanswered edge.
    task automatic test_timeout();
        for (int i = 0; i < 13; i++) tick();
        checks++;
        if (mem_req !== 1'b1 || erro_busca !== 1'b0) begin
            errors++;
            $display("FAIL before_timeout: got req=%b erro=%b, want 1 0", mem_req, erro_busca);
        end
        tick();
`ifdef BUSCA_TIMEOUT_EN
        checks++;
        if (mem_req !== 1'b0 || erro_busca !== 1'b1 || instru_valida !== 1'b0 || instru !== 8'h00) begin
            errors++;
            $display("FAIL timeout: got req=%b erro=%b valida=%b instru=%h, want 0 1 0 00",
                     mem_req, erro_busca, instru_valida, instru);
        end
        fetch(8'h99);
        retire(1'b0, 1'b0, 8'h00);
        checks++;
        if (mem_req !== 1'b0 || erro_busca !== 1'b1 || instru_valida !== 1'b0 || pc !== 8'h00) begin
            errors++;
            $display("FAIL stuck_in_erro: got req=%b erro=%b valida=%b pc=%h, want 0 1 0 00",
                     mem_req, erro_busca, instru_valida, pc);
        end
`else
        for (int i = 0; i < 6; i++) tick();
        checks++;
        if (mem_req !== 1'b1 || erro_busca !== 1'b0 || mem_addr !== 8'h00) begin
            errors++;
            $display("FAIL no_timeout: got req=%b erro=%b addr=%h, want 1 0 00",
                     mem_req, erro_busca, mem_addr);
        end
`endif
    endtask

    task automatic test_random();
        logic [7:0] m_pc, m_instru;
        logic       m_started, m_fetching, m_valid, m_err;
        int         m_wait;
        logic [7:0] exp_instru;
        reset = 1'b1;
        #1;
        tick();
        reset = 1'b0;
        m_pc = 8'h00; m_instru = 8'h00;
        m_started = 1'b0; m_fetching = 1'b0; m_valid = 1'b0; m_err = 1'b0; m_wait = 0;
        for (int n = 0; n < 600; n++) begin
            mem_ack    = ($urandom_range(0, 99) < 55);
            mem_data   = 8'($urandom);
            escritaPC  = ($urandom_range(0, 1) == 1);
            pula       = ($urandom_range(0, 1) == 1);
            comparador = ($urandom_range(0, 1) == 1);
            alvo       = 8'($urandom);
            if (m_err) begin
                // sticky until reset
            end else if (!m_started) begin
                m_started  = 1'b1;
                m_fetching = 1'b1;
            end else if (m_fetching) begin
                if (mem_ack) begin
                    m_instru   = mem_data;
                    m_valid    = 1'b1;
                    m_fetching = 1'b0;
                    m_wait     = 0;
                end else begin
                    m_wait++;
`ifdef BUSCA_TIMEOUT_EN
                    if (m_wait == 15) begin
                        m_err      = 1'b1;
                        m_fetching = 1'b0;
                    end
`endif
                end
            end else if (m_valid && escritaPC) begin
                m_pc       = (pula && comparador) ? alvo : 8'((m_pc + 1) % 256);
                m_valid    = 1'b0;
                m_fetching = 1'b1;
                m_wait     = 0;
            end
            tick();
            exp_instru = m_err ? 8'h00 : m_instru;
            checks++;
            if (mem_req !== m_fetching || mem_addr !== m_pc || instru_valida !== m_valid ||
                instru !== exp_instru || pc !== m_pc || erro_busca !== m_err) begin
                errors++;
                $display("FAIL random[%0d]: got req=%b addr=%h valida=%b instru=%h pc=%h erro=%b, want %b %h %b %h %h %b",
                         n, mem_req, mem_addr, instru_valida, instru, pc, erro_busca,
                         m_fetching, m_pc, m_valid, exp_instru, m_pc, m_err);
            end
        end
        mem_ack = 1'b0; escritaPC = 1'b0; pula = 1'b0; comparador = 1'b0;
    endtask

    initial begin
        reset = 1'b1; mem_ack = 1'b0; mem_data = 8'h00;
        escritaPC = 1'b0; pula = 1'b0; comparador = 1'b0; alvo = 8'h00;
        test_reset();
        test_first_fetch();
        test_increment();
        test_branch();
        test_wrap();
        test_reset_mid_fetch();
        test_timeout();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/unidade_busca.md
UNIDADE_BUSCA -- requirements
Module: unidade_busca

Interface
REQ-001 SHALL have port: clk  input  1  single system clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port: mem_addr  output  8  instruction memory address; equals pc while fetching.
REQ-004 SHALL have port: mem_req  output  1  fetch request to instruction memory.
REQ-005 SHALL have port: mem_ack  input  1  memory response strobe; mem_data is valid in the same cycle.
REQ-006 SHALL have port: mem_data  input  8  instruction byte returned by memory.
REQ-007 SHALL have port: instru  output  8  instruction presented to controleUnit.
REQ-008 SHALL have port: instru_valida  output  1  instru holds a fetched instruction.
REQ-009 SHALL have port: escritaPC  input  1  from controleUnit; retire the current instruction and update pc.
REQ-010 SHALL have port: pula  input  1  from controleUnit; current instruction is a branch.
REQ-011 SHALL have port: comparador  input  1  from controleUnit/ULA; branch condition true.
REQ-012 SHALL have port: alvo  input  8  branch target address.
REQ-013 SHALL have port: pc  output  8  current program counter.
REQ-014 SHALL have port: erro_busca  output  1  sticky fetch-timeout flag.

Function
REQ-015 SHALL implement the FSM states OCIOSO, BUSCA and ENTREGA (and ERRO when the REQ-029 macro is defined).
REQ-016 SHALL move from OCIOSO to BUSCA on the first rising edge after reset deasserts.
REQ-017 In BUSCA: SHALL drive mem_req=1 and mem_addr=pc, and hold both stable until mem_ack.
REQ-018 On a cycle in BUSCA with mem_ack=1: SHALL latch mem_data into instru, enter ENTREGA, and drop mem_req on the next cycle; instru_valida=1 exactly one cycle after the ack.
REQ-019 SHALL ignore mem_ack outside BUSCA.
REQ-020 In ENTREGA: SHALL hold instru and instru_valida=1 until escritaPC=1.
REQ-021 On a cycle in ENTREGA with escritaPC=1 and (pula AND comparador)=1: SHALL load pc<=alvo, else SHALL load pc<=pc+1 modulo 256 (0xFF wraps to 0x00).
REQ-022 On the same edge as REQ-021: SHALL clear instru_valida and enter BUSCA; the next mem_req is asserted with the new pc.
REQ-023 SHALL ignore escritaPC, pula and comparador outside ENTREGA.
REQ-024 When pula=1 and comparador=0, the branch is not taken and pc SHALL increment.
REQ-025 SHALL have at most one outstanding fetch; mem_req SHALL never be asserted in ENTREGA.

Reset
REQ-026 Reset SHALL asynchronously force: pc=0x00, state OCIOSO, mem_req=0, mem_addr=0x00, instru=0x00, instru_valida=0, erro_busca=0.
REQ-027 Reset asserted mid-fetch SHALL drop mem_req immediately (combinationally via the registers); a mem_ack arriving during or after reset, before a new request, SHALL be ignored.
REQ-028 After reset release, the first fetch SHALL be at address 0x00.

Configuration
REQ-029 Macro BUSCA_TIMEOUT_EN: when defined, a 4-bit wait counter SHALL count cycles in BUSCA without mem_ack.
  - On reaching 15: enter ERRO; drop mem_req; set erro_busca=1 (sticky until reset); present instru=0x00 with instru_valida=0.
  - ERRO SHALL be left only by reset.
REQ-030 When BUSCA_TIMEOUT_EN is undefined: there SHALL be no counter and no ERRO state, BUSCA SHALL wait indefinitely, and erro_busca SHALL be tied to 0.

Structure
REQ-031 Shared package busca_pkg SHALL hold: the FSM state encoding, PC_RESET=8'h00, INSTR_NOP=8'h00 and TIMEOUT_MAX=4'd15.
REQ-032 Sub-module contador_pc SHALL hold the pc register, the increment/branch mux and the asynchronous reset; the FSM stays in unidade_busca.

Verification
REQ-033 Reset then release; memory acks after 2 cycles with 0x3A -> first mem_addr=0x00; instru=0x3A, instru_valida=1 one cycle after ack.
REQ-034 escritaPC=1, pula=0 in ENTREGA with pc=0x05 -> pc=0x06; instru_valida=0; mem_req=1 with mem_addr=0x06 on the next cycle.
REQ-035 escritaPC=1, pula=1, comparador=1, alvo=0x80 -> pc=0x80; repeat with comparador=0 -> pc=0x81 from pc=0x80.
REQ-036 pc=0xFF, escritaPC=1, pula=0 -> pc=0x00, next fetch at 0x00.
REQ-037 Assert reset while mem_req=1 at pc=0x10, ack during reset -> mem_req=0 immediately; ack ignored; post-reset fetch at 0x00 with instru_valida=0 until a new ack.
REQ-038 With BUSCA_TIMEOUT_EN: withhold mem_ack for 15 cycles -> erro_busca=1, mem_req=0, stuck in ERRO until reset; without the macro: mem_req stays 1, erro_busca=0.
